// File: rtl/sel_demux1_2.sv
// 1-to-2 valid/ready stream distributor with a 2-entry buffer and a delivered-beat counter per lane.
// Optional packet lock (macro SEL_DEMUX_PKT_LOCK_EN) keeps every beat of a packet on the lane of its first beat.
module sel_demux1_2 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_SEL,
    input  logic              IN_VALID,
`ifdef SEL_DEMUX_PKT_LOCK_EN
    input  logic              IN_LAST,
    output logic              OUT0_LAST,
    output logic              OUT1_LAST,
`endif
    output logic              IN_READY,
    output logic [DATA_W-1:0] OUT0_DATA,
    output logic              OUT0_VALID,
    input  logic              OUT0_READY,
    output logic [DATA_W-1:0] OUT1_DATA,
    output logic              OUT1_VALID,
    input  logic              OUT1_READY,
    output logic [CNT_W-1:0]  CNT0,
    output logic [CNT_W-1:0]  CNT1
);

    logic [DATA_W-1:0] mem [2][2];
    logic              wp  [2];
    logic              rp  [2];
    logic [1:0]        occ [2];
    logic [CNT_W-1:0]  dcnt [2];

    logic       route_lane;
    logic       push;
    logic [1:0] push_v;
    logic [1:0] pop_v;
    logic [1:0] out_ready;

    assign out_ready = {OUT1_READY, OUT0_READY};

    // Ready looks only at registered occupancy, so a pop never passes space through in the same cycle.
    assign IN_READY = (occ[route_lane] != 2'd2);
    assign push     = IN_VALID & IN_READY;
    assign push_v   = {push & route_lane, push & ~route_lane};

    always_comb begin
        pop_v = 2'b00;
        for (int l = 0; l < 2; l++) begin
            pop_v[l] = (occ[l] != 2'd0) & out_ready[l];
        end
    end

`ifdef SEL_DEMUX_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} lock_state_t;

    lock_state_t state, state_nxt;
    logic        lock_lane, lock_lane_nxt;
    logic        last_mem [2][2];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            lock_lane <= 1'b0;
        end else begin
            state     <= state_nxt;
            lock_lane <= lock_lane_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        lock_lane_nxt = lock_lane;
        case (state)
            IDLE: begin
                if (push && !IN_LAST) begin
                    state_nxt     = LOCKED;
                    lock_lane_nxt = IN_SEL;
                end
            end
            LOCKED: begin
                if (push && IN_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        route_lane = IN_SEL;
        if (state == LOCKED) route_lane = lock_lane;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int l = 0; l < 2; l++) begin
                last_mem[l][0] <= 1'b0;
                last_mem[l][1] <= 1'b0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (push_v[l]) last_mem[l][wp[l]] <= IN_LAST;
            end
        end
    end

    assign OUT0_LAST = last_mem[0][rp[0]];
    assign OUT1_LAST = last_mem[1][rp[1]];
`else
    assign route_lane = IN_SEL;
`endif

    // Lane buffers: push and pop on the same lane leave occupancy unchanged while both pointers move.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int l = 0; l < 2; l++) begin
                mem[l][0] <= '0;
                mem[l][1] <= '0;
                wp[l]     <= 1'b0;
                rp[l]     <= 1'b0;
                occ[l]    <= 2'd0;
                dcnt[l]   <= '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (push_v[l]) begin
                    mem[l][wp[l]] <= IN_DATA;
                    wp[l]         <= ~wp[l];
                end
                if (pop_v[l]) begin
                    rp[l]   <= ~rp[l];
                    dcnt[l] <= dcnt[l] + 1'b1;
                end
                case ({push_v[l], pop_v[l]})
                    2'b10:   occ[l] <= occ[l] + 2'd1;
                    2'b01:   occ[l] <= occ[l] - 2'd1;
                    default: occ[l] <= occ[l];
                endcase
            end
        end
    end

    assign OUT0_VALID = (occ[0] != 2'd0);
    assign OUT1_VALID = (occ[1] != 2'd0);
    assign OUT0_DATA  = mem[0][rp[0]];
    assign OUT1_DATA  = mem[1][rp[1]];
    assign CNT0       = dcnt[0];
    assign CNT1       = dcnt[1];

endmodule

// File: doc/sel_demux1_2.md
Name: sel_demux1_2

Overview:
- 1-to-2 stream distributor; the inverse of the team's 2:1 selector.
- Routes each input beat to output lane 0 (IN_SEL=0) or lane 1 (IN_SEL=1) using a valid/ready handshake.
- Each lane has a 2-entry buffer, so a stalled lane never blocks traffic addressed to the other lane.
- Sits between a single producer and two independent consumers.

Parameters:
- DATA_W, 8, width of data beats.
- CNT_W, 16, width of per-lane delivered-beat counters.

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RST_N  input  1  synchronous active-low reset.
- IN_DATA  input  DATA_W  input beat.
- IN_SEL  input  1  destination lane of the current beat.
- IN_VALID  input  1  input beat present.
- IN_READY  output  1  beat accepted this cycle when high together with IN_VALID.
- OUT0_DATA  output  DATA_W  lane 0 head beat.
- OUT0_VALID  output  1  lane 0 holds a beat.
- OUT0_READY  input  1  lane 0 consumer accepts.
- OUT1_DATA  output  DATA_W  lane 1 head beat.
- OUT1_VALID  output  1  lane 1 holds a beat.
- OUT1_READY  input  1  lane 1 consumer accepts.
- CNT0  output  CNT_W  beats delivered on lane 0.
- CNT1  output  CNT_W  beats delivered on lane 1.

Behaviour:
- Reset (RST_N low at a CLK edge): both lane counts 0, read/write pointers 0, buffer contents 0.
  - OUTx_VALID=0, OUTx_DATA=0, CNT0=CNT1=0.
  - Reset asserted mid-transfer discards all buffered beats; no output handshake completes in the reset cycle.
- Lane buffer: 2 entries, 1-bit write pointer, 1-bit read pointer, count 0..2.
  - OUTx_VALID = (count != 0); OUTx_DATA = entry at the read pointer.
- IN_READY = (count of lane IN_SEL) < 2. Combinational on IN_SEL and the registered counts only; never on OUTx_READY.
- Push: IN_VALID & IN_READY writes IN_DATA into lane IN_SEL and increments that lane's write pointer.
  - IN_SEL is meaningful only in the accepting cycle.
- Pop: OUTx_VALID & OUTx_READY increments the lane's read pointer and increments CNTx.
- Latency: an accepted beat appears on OUTx the next cycle when the lane was empty; otherwise it follows beats already queued.
- Simultaneous push and pop on one lane: count unchanged, both pointers advance. Legal at count 1 or 2? Only counts 0..1 can push; a pop at count 2 frees space visible next cycle (no same-cycle pass-through).
- Pop on one lane and push on the other in the same cycle are fully independent.
- Ordering: per-lane FIFO order preserved. No ordering relation between lanes.
- CNTx wraps from 2^CNT_W-1 to 0 silently.
- OUTx_DATA is stable while OUTx_VALID=1 and OUTx_READY=0.

Optional Feature:
- Macro SEL_DEMUX_PKT_LOCK_EN.
- Defined: adds input IN_LAST (1 bit) and outputs OUT0_LAST and OUT1_LAST (1 bit each, stored alongside data).
  - Lock FSM with states IDLE and LOCKED; LOCK_LANE register resets to 0.
  - IDLE: routing uses IN_SEL. An accepted beat with IN_LAST=0 latches LOCK_LANE=IN_SEL and moves to LOCKED. An accepted beat with IN_LAST=1 stays in IDLE.
  - LOCKED: IN_SEL is ignored; beats route to LOCK_LANE and IN_READY uses LOCK_LANE's count. An accepted beat with IN_LAST=1 returns to IDLE.
  - Reset returns to IDLE.
- Undefined: no IN_LAST/OUTx_LAST ports, no FSM; every beat routes by its own IN_SEL.

Test Plan:
- Reset, then IN_VALID=1, IN_SEL=0, IN_DATA=8'hA5, OUT0_READY=1 -> next cycle OUT0_VALID=1, OUT0_DATA=A5; following cycle CNT0=1, OUT1_VALID=0.
- Hold OUT1_READY=0, push 3 beats to lane 1 -> first 2 accepted, IN_READY=0 on the 3rd. Switch IN_SEL=0 -> accepted immediately (lane independence).
- Lane 0 at count 1, simultaneous push 8'h11 and pop -> count stays 1, OUT0_DATA=11 next cycle, CNT0 increments.
- Preload CNT1 to 2^CNT_W-1 via deliveries, deliver 1 more -> CNT1=0.
- Lane 0 and lane 1 each full, assert RST_N=0 for one cycle -> all VALID=0, counts and CNTs=0, IN_READY=1.
- With SEL_DEMUX_PKT_LOCK_EN: 3-beat packet, first beat IN_SEL=1, later beats IN_SEL=0, last beat IN_LAST=1 -> all 3 on lane 1 with OUT1_LAST=1 on the 3rd only. Next beat with IN_SEL=0 goes to lane 0.
